// File: rtl/adder_error_evaluator_pkg.sv
// Shared types and width helpers for the approximate-adder error evaluator.
// The state enum and counter-width rules are kept here so sibling evaluators stay consistent.
package adder_error_evaluator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Input vector width seen by the circuit under evaluation.
   function automatic int vec_width(input int op_w);
      return 2 * op_w;
   endfunction

   // Error count must reach 2^(2*op_w), which needs one extra bit.
   function automatic int cnt_width(input int op_w);
      return 2 * op_w + 1;
   endfunction

   // Sum of errors must reach 2^(2*op_w) * (2^out_w - 1).
   function automatic int sum_width(input int op_w, input int out_w);
      return 2 * op_w + out_w;
   endfunction

endpackage

// File: rtl/adder_err_metric.sv
// Combinational error unit: exact sum of a and b, and the absolute difference
// between that sum and the result produced by an approximate adder.
module adder_err_metric #(
   parameter int OP_W  = 4,
   parameter int OUT_W = 5
) (
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [OUT_W-1:0] result,
   output logic [OUT_W-1:0] abs_err,
   output logic             err_nz
);

   logic [OUT_W:0] exact;
   logic [OUT_W:0] diff;
   logic [OUT_W:0] mag;

   assign exact = (OUT_W+1)'(a) + (OUT_W+1)'(b);

   // Signed OUT_W+1-bit difference; the sign bit selects negation.
   assign diff = {1'b0, result} - exact;
   assign mag  = diff[OUT_W] ? -diff : diff;

   // Because exact <= 2^OUT_W - 2, the magnitude never needs the top bit.
   assign abs_err = mag[OUT_W-1:0];
   assign err_nz  = |mag;

endmodule

// File: rtl/adder_error_evaluator.sv
// Sweeps every operand pair through an external combinational approximate adder
// and accumulates max, count and sum of absolute errors, then reports pass against ET.
module adder_error_evaluator
   import adder_error_evaluator_pkg::*;
#(
   parameter int OP_W  = 4,
   parameter int OUT_W = 5,
   parameter int ET    = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic [vec_width(OP_W)-1:0]        dut_in,
   input  logic [OUT_W-1:0]                  dut_out,
   output logic                              busy,
   output logic                              done,
   output logic [OUT_W-1:0]                  max_err,
   output logic [cnt_width(OP_W)-1:0]        err_cnt,
   output logic [sum_width(OP_W, OUT_W)-1:0] sum_abs_err,
   output logic                              pass
);

   localparam int IN_W  = vec_width(OP_W);
   localparam int CNT_W = cnt_width(OP_W);
   localparam int SUM_W = sum_width(OP_W, OUT_W);

   localparam logic [IN_W-1:0]  LAST_VEC = '1;
   localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

   state_t           state;
   logic [OUT_W-1:0] abs_err;
   logic             err_nz;
   logic [OUT_W-1:0] max_next;

   adder_err_metric #(
      .OP_W  (OP_W),
      .OUT_W (OUT_W)
   ) u_metric (
      .a       (dut_in[IN_W-1:OP_W]),
      .b       (dut_in[OP_W-1:0]),
      .result  (dut_out),
      .abs_err (abs_err),
      .err_nz  (err_nz)
   );

   // Max including the current vector, so pass can be decided on the last edge.
   assign max_next = (abs_err > max_err) ? abs_err : max_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dut_in      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         max_err     <= '0;
         err_cnt     <= '0;
         sum_abs_err <= '0;
         pass        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RUN;
                  dut_in      <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  max_err     <= '0;
                  err_cnt     <= '0;
                  sum_abs_err <= '0;
                  pass        <= 1'b0;
               end
            end
            RUN: begin
               max_err     <= max_next;
               sum_abs_err <= sum_abs_err + SUM_W'(abs_err);
               if (err_nz) begin
                  err_cnt <= err_cnt + CNT_W'(1);
               end
               // dut_in stays on the last vector while results are held.
               if (dut_in == LAST_VEC) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (max_next <= ET_V);
               end else begin
                  dut_in <= dut_in + IN_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_error_evaluator.sv
// Bench for adder_error_evaluator: emulates several approximate adders and checks
// every RUN cycle and the final metrics against an arithmetic model of the sweep.
module tb_adder_error_evaluator;

   localparam int OP_W  = 4;
   localparam int OUT_W = 5;
   localparam int ET    = 3;
   localparam int NV    = 1 << (2 * OP_W);

   localparam int M_EXACT = 0;
   localparam int M_ZERO  = 1;
   localparam int M_BIT0  = 2;
   localparam int M_XOR4  = 3;
   localparam int M_LUT   = 4;
   localparam int M_XOR3  = 5;

   logic                    clk;
   logic                    rst;
   logic                    start;
   logic [2*OP_W-1:0]       dut_in;
   logic [OUT_W-1:0]        dut_out;
   logic                    busy;
   logic                    done;
   logic [OUT_W-1:0]        max_err;
   logic [2*OP_W:0]         err_cnt;
   logic [2*OP_W+OUT_W-1:0] sum_abs_err;
   logic                    pass;

   int               mode;
   logic [OUT_W-1:0] rand_lut [NV];
   logic [OUT_W-1:0] lut_val;
   int               checks;
   int               failures;

   adder_error_evaluator #(
      .OP_W  (OP_W),
      .OUT_W (OUT_W),
      .ET    (ET)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dut_in      (dut_in),
      .dut_out     (dut_out),
      .busy        (busy),
      .done        (done),
      .max_err     (max_err),
      .err_cnt     (err_cnt),
      .sum_abs_err (sum_abs_err),
      .pass        (pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Emulated approximate adders.
   function automatic logic [OUT_W-1:0] model_out(input int m, input int v, input logic [OUT_W-1:0] lv);
      int s;
      s = (v / (1 << OP_W)) + (v % (1 << OP_W));
      case (m)
         M_EXACT: return OUT_W'(s);
         M_ZERO:  return '0;
         M_BIT0:  return OUT_W'(s | 1);
         M_XOR4:  return OUT_W'(s ^ 4);
         M_LUT:   return lv;
         M_XOR3:  return OUT_W'(s ^ 3);
         default: return OUT_W'(s);
      endcase
   endfunction

   assign lut_val = rand_lut[dut_in];
   assign dut_out = model_out(mode, int'(dut_in), lut_val);

   function automatic int err_of(input int v);
      int exact;
      int got;
      exact = (v / (1 << OP_W)) + (v % (1 << OP_W));
      got   = int'(model_out(mode, v, rand_lut[v]));
      return (got > exact) ? got - exact : exact - got;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_dut_in"}, dut_in, 0);
      check({tag, "_max"}, max_err, 0);
      check({tag, "_cnt"}, err_cnt, 0);
      check({tag, "_sum"}, sum_abs_err, 0);
      check({tag, "_pass"}, pass, 0);
   endtask

   // Full sweep from a start pulse (or held start) with per-cycle checks.
   // Called at a negedge with the DUT in IDLE or DONE.
   task automatic run_sweep(input string tag, input bit hold_start);
      int acc_max;
      int acc_cnt;
      int acc_sum;
      int e;
      acc_max = 0;
      acc_cnt = 0;
      acc_sum = 0;
      start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      for (int k = 0; k < NV; k++) begin
         check({tag, "_run_busy"}, busy, 1);
         check({tag, "_run_done"}, done, 0);
         check({tag, "_run_vec"}, dut_in, k);
         check({tag, "_run_max"}, max_err, acc_max);
         check({tag, "_run_cnt"}, err_cnt, acc_cnt);
         check({tag, "_run_sum"}, sum_abs_err, acc_sum);
         e = err_of(k);
         if (e > acc_max) acc_max = e;
         if (e != 0) acc_cnt++;
         acc_sum += e;
         if (k == NV - 1) start = 1'b0;
         @(negedge clk);
      end
      for (int h = 0; h < 3; h++) begin
         check({tag, "_end_busy"}, busy, 0);
         check({tag, "_end_done"}, done, 1);
         check({tag, "_end_vec"}, dut_in, NV - 1);
         check({tag, "_end_max"}, max_err, acc_max);
         check({tag, "_end_cnt"}, err_cnt, acc_cnt);
         check({tag, "_end_sum"}, sum_abs_err, acc_sum);
         check({tag, "_end_pass"}, pass, (acc_max <= ET) ? 1 : 0);
         @(negedge clk);
      end
   endtask

   task automatic check_final(input string tag, input int mx, input int cnt, input int sm, input int ps);
      check({tag, "_lit_max"}, max_err, mx);
      check({tag, "_lit_cnt"}, err_cnt, cnt);
      check({tag, "_lit_sum"}, sum_abs_err, sm);
      check({tag, "_lit_pass"}, pass, ps);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mode     = M_EXACT;
      rst      = 1'b1;
      start    = 1'b0;
      for (int v = 0; v < NV; v++) rand_lut[v] = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle");

      mode = M_EXACT;
      run_sweep("exact", 1'b0);
      check_final("exact", 0, 0, 0, 1);

      mode = M_ZERO;
      run_sweep("zero", 1'b0);
      check_final("zero", 30, 255, 3840, 0);

      mode = M_BIT0;
      run_sweep("bit0", 1'b0);
      check_final("bit0", 1, 128, 128, 1);

      mode = M_XOR4;
      run_sweep("xor4", 1'b0);
      check_final("xor4", 4, 256, 1024, 0);

      // Errors reach exactly ET: boundary pass.
      mode = M_XOR3;
      run_sweep("xor3", 1'b0);
      check("xor3_lit_max", max_err, 3);
      check("xor3_lit_pass", pass, 1);

      // Reset in the middle of a run, then a clean rerun.
      mode = M_ZERO;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (dut_in != 8'd100 && dut_in != 8'd255) @(negedge clk);
      check("midrst_vec", dut_in, 100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("midrst");
      @(negedge clk);
      check_idle("midrst_hold");
      run_sweep("after_rst", 1'b0);
      check_final("after_rst", 30, 255, 3840, 0);

      // start held through RUN, then restart from DONE.
      mode = M_BIT0;
      run_sweep("hold", 1'b1);
      run_sweep("restart", 1'b0);
      check_final("restart", 1, 128, 128, 1);

      // Random approximate adders: fully random outputs, then sparse perturbations.
      mode = M_LUT;
      for (int r = 0; r < 4; r++) begin
         for (int v = 0; v < NV; v++) begin
            int s;
            s = (v / (1 << OP_W)) + (v % (1 << OP_W));
            if (r == 0)
               rand_lut[v] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
            else if ($urandom_range(0, 15) == 0)
               rand_lut[v] = OUT_W'(s + int'($urandom_range(0, 2 * r)) - r);
            else
               rand_lut[v] = OUT_W'(s);
         end
         run_sweep($sformatf("rand%0d", r), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
